// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline control logic.
package cpu_pkg;

    localparam int REG_IDX_W = 5;

    // X31 reads as zero, so a write to it never creates a real dependency.
    localparam logic [REG_IDX_W-1:0] XZR = 5'd31;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that needs the result of
// a load still sitting in EX. Purely combinational so other units can reuse it.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rn,
    input  logic [REG_IDX_W-1:0] id_rm,
    input  logic                 id_uses_rm,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    output logic                 lu
);

    logic rn_match;
    logic rm_match;

    // Compare the load destination against each source the ID instruction reads.
    always_comb begin
        rn_match = (ex_rd == id_rn);
        rm_match = id_uses_rm && (ex_rd == id_rm);
        lu       = ex_memread && (ex_rd != XZR) && (rn_match || rm_match);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: drives the hold enables of every pipeline register
// bank plus the IF/ID and ID/EX flush controls, and remembers a taken-branch
// flush that arrives while data memory is stalling the pipe.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal operation, no flush outstanding
//   PEND  | a taken branch arrived during a memory freeze; flush on release
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rn,
    input  logic [REG_IDX_W-1:0] id_rm,
    input  logic                 id_uses_rm,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    input  logic                 br_taken,
    input  logic                 mem_busy,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 flush_pend,
    output logic [CNT_W-1:0]     stall_cnt
);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             fl;

    load_use_detect u_lu (
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rm (id_uses_rm),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .lu         (lu)
    );

    // State and stall counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, enables/flushes and counter update; memory freeze beats
    // flush, and flush beats a load-use bubble since that instruction dies.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fl         = br_taken || (state_q == PEND);

        if (!reset) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = RUN;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            // A branch seen during the freeze (or an older one) waits here.
            if (fl) begin
                state_d = PEND;
            end
        end else if (fl) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        if (reset && !pc_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign flush_pend = reset && (state_q == PEND);
    assign stall_cnt  = cnt_q;

endmodule
